// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store control stage: funct3 encodings,
// FSM state type, default memory size and small request-decoding helpers.
package lsu_mem_ctrl_pkg;

  localparam int MEM_BYTES_DEFAULT = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;

  // Stores only know B/H/W; loads additionally accept the unsigned variants.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 inside {F3_B, F3_H, F3_W});
    else    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // Sub-word store: overlay the low byte/halfword of the store data on the read word.
  function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                              input logic [31:0] word,
                                              input logic [31:0] wdata);
    if (f3 == F3_H) return {word[31:16], wdata[15:0]};
    else            return {word[31:8],  wdata[7:0]};
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extraction: selects byte/halfword/word from a little-endian
// memory word and applies sign or zero extension according to funct3.
module lsu_load_extend
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  // NOTE: a combinational block must assign every output on every path;
  // the default first makes that true by construction and prevents a latch.
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{i_word[7]}},  i_word[7:0]};
      F3_H:    o_data = {{16{i_word[15]}}, i_word[15:0]};
      F3_BU:   o_data = {24'h0, i_word[7:0]};
      F3_HU:   o_data = {16'h0, i_word[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store control in front of a byte-addressed, word-wide data memory.
// SB/SH run as read-modify-write; optional range check via LSU_BOUND_CHECK_EN.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        fault,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  logic [31:0] r_hold_addr;
  logic [31:0] r_hold_word;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_fault;

  logic        w_out_of_range;
  logic        w_reject;
  logic        w_accept;
  logic        w_load_ok;
  logic        w_rmw_start;
  logic [31:0] w_ext;

`ifdef LSU_BOUND_CHECK_EN
  // Highest legal address still leaves room for a full 4-byte access.
  assign w_out_of_range = (req_addr > 32'(MEM_BYTES - 4));
`else
  logic w_unused_bound;
  assign w_out_of_range = 1'b0;
  // Keeps the size parameter referenced when the range check is compiled out.
  assign w_unused_bound = ^32'(MEM_BYTES);
`endif

  assign w_reject    = f3_illegal(req_we, req_funct3) || w_out_of_range;
  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_load_ok   = w_accept && !w_reject && !req_we;
  assign w_rmw_start = w_accept && !w_reject && req_we && (req_funct3 != F3_W);

  lsu_load_extend u_load_extend (
    .i_funct3 (req_funct3),
    .i_word   (mem_rdata),
    .o_data   (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_ce      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !w_reject) begin
          mem_ce   = 1'b1;
          mem_addr = req_addr;
          if (req_we && req_funct3 == F3_W) begin
            mem_we    = 1'b1;
            mem_wdata = req_wdata;
          end else if (req_we) begin
            w_state_nxt = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_ce      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = r_hold_addr;
        mem_wdata   = r_hold_word;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  // Reset returns to IDLE immediately, which also cancels a pending RMW write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold_addr <= 32'h0;
      r_hold_word <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_load_ok;
      r_fault     <= w_accept && w_reject;
      if (w_load_ok) r_rsp_data <= w_ext;
      if (w_rmw_start) begin
        r_hold_addr <= req_addr;
        r_hold_word <= merge_store(req_funct3, mem_rdata, req_wdata);
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign fault     = r_fault;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-array memory, byte-level reference
// model, directed scenarios plus randomized traffic. Honours LSU_BOUND_CHECK_EN.
module tb_lsu_mem_ctrl;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        fault;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem     [0:MEM_BYTES-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic        bd_en;
  logic [31:0] bd_addr;
  logic [31:0] bd_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .fault      (fault),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Byte-addressed memory, wrapping at MEM_BYTES; one process owns the array.
  assign mem_rdata = {mem[10'(mem_addr + 32'd3)], mem[10'(mem_addr + 32'd2)],
                      mem[10'(mem_addr + 32'd1)], mem[10'(mem_addr)]};

  always @(posedge clk) begin
    if (bd_en) begin
      for (int k = 0; k < 4; k++) mem[10'(bd_addr + 32'(k))] <= bd_word[8*k +: 8];
    end else if (mem_ce && mem_we) begin
      for (int k = 0; k < 4; k++) mem[10'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[10'(a + 32'd3)], ref_mem[10'(a + 32'd2)],
            ref_mem[10'(a + 32'd1)], ref_mem[10'(a)]};
  endfunction

  function automatic bit ref_illegal(input logic we, input logic [2:0] f3,
                                     input logic [31:0] a);
    bit bad;
    if (we) bad = (f3 > 3'd2);
    else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LSU_BOUND_CHECK_EN
    if (a > 32'(MEM_BYTES - 4)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = ref_word(a);
    case (f3)
      3'd0:    return 32'($signed(w[7:0]));
      3'd1:    return 32'($signed(w[15:0]));
      3'd4:    return 32'(w[7:0]);
      3'd5:    return 32'(w[15:0]);
      default: return w;
    endcase
  endfunction

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    bd_en = 1'b1; bd_addr = a; bd_word = w;
    for (int k = 0; k < 4; k++) ref_mem[10'(a + 32'(k))] = w[8*k +: 8];
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  // One request, entered and left at posedge+1; checks every cycle it spans.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string name);
    bit          bad, sub;
    logic [31:0] exp_rsp;
    logic [66:0] exp_bus;
    bad     = ref_illegal(we, f3, a);
    sub     = we && !bad && (f3 != 3'd2);
    exp_rsp = ref_load(f3, a);
    if (bad)                  exp_bus = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    else if (we && f3 == 3'd2) exp_bus = {1'b1, 1'b1, 1'b1, a, wd};
    else                      exp_bus = {1'b1, 1'b1, 1'b0, a, 32'h0};
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_ce, mem_we, mem_addr, mem_wdata} !== exp_bus) begin
      errors++;
      $display("FAIL %s bus: got %h expected %h", name,
               {req_ready, mem_ce, mem_we, mem_addr, mem_wdata}, exp_bus);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (we && !bad && f3 == 3'd2)
      for (int k = 0; k < 4; k++) ref_mem[10'(a + 32'(k))] = wd[8*k +: 8];
    checks++;
    if ({rsp_valid, fault} !== {!bad && !we, bad}) begin
      errors++;
      $display("FAIL %s flags: got valid=%b fault=%b expected valid=%b fault=%b",
               name, rsp_valid, fault, !bad && !we, bad);
    end
    if (!bad && !we) begin
      checks++;
      if (rsp_data !== exp_rsp) begin
        errors++;
        $display("FAIL %s rsp_data: got %h expected %h", name, rsp_data, exp_rsp);
      end
    end
    if (sub) begin
      ref_mem[10'(a)] = wd[7:0];
      if (f3 == 3'd1) ref_mem[10'(a + 32'd1)] = wd[15:8];
      @(negedge clk);
      checks++;
      if ({req_ready, mem_ce, mem_we, mem_addr, mem_wdata} !== {3'b011, a, ref_word(a)}) begin
        errors++;
        $display("FAIL %s rmw write: got %h expected %h", name,
                 {req_ready, mem_ce, mem_we, mem_addr, mem_wdata}, {3'b011, a, ref_word(a)});
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, fault} !== 2'b00) begin
        errors++;
        $display("FAIL %s rmw flags: got %b expected 00", name, {rsp_valid, fault});
      end
    end
    if (we && !bad) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (mem[10'(a + 32'(k))] !== ref_mem[10'(a + 32'(k))]) begin
          errors++;
          $display("FAIL %s byte %h: got %h expected %h", name, 10'(a + 32'(k)),
                   mem[10'(a + 32'(k))], ref_mem[10'(a + 32'(k))]);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; bd_en = 1'b0; bd_addr = 32'h0; bd_word = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, fault, mem_ce, mem_we, mem_addr, mem_wdata}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset outputs: got ready=%b valid=%b data=%h fault=%b ce=%b we=%b addr=%h wdata=%h",
               req_ready, rsp_valid, rsp_data, fault, mem_ce, mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < MEM_BYTES; i += 4) poke_word(32'(i), $urandom);
  endtask

  task automatic test_loads();
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F80, 32'h55AA7F80};
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
    poke_word(32'h10, 32'h55AA7F80);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], 32'h10, 32'h0, "load_0x10");
      checks++;
      if (rsp_data !== exp[i]) begin
        errors++;
        $display("FAIL load_const f3=%0d: got %h expected %h", f3s[i], rsp_data, exp[i]);
      end
    end
    issue(1'b0, 3'd5, 32'h11, 32'h0, "lhu_unaligned");
    issue(1'b0, 3'd0, 32'h12, 32'h0, "lb_neg");
  endtask

  task automatic test_sw();
    issue(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, "sw_0x20");
    issue(1'b0, 3'd2, 32'h20, 32'h0, "lw_0x20");
    checks++;
    if (rsp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_readback: got %h expected %h", rsp_data, 32'hDEADBEEF);
    end
  endtask

  task automatic test_sub_store();
    poke_word(32'h30, 32'h11223344);
    poke_word(32'h34, 32'h000000EE);
    issue(1'b1, 3'd0, 32'h31, 32'h000000AB, "sb_0x31");
    issue(1'b0, 3'd2, 32'h30, 32'h0, "lw_0x30");
    checks++;
    if (rsp_data !== 32'h1122AB44) begin
      errors++;
      $display("FAIL sb_readback: got %h expected %h", rsp_data, 32'h1122AB44);
    end
    issue(1'b1, 3'd1, 32'h33, 32'h0000CAFE, "sh_0x33");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    poke_word(32'h50, 32'h01020304);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h52; req_wdata = 32'h1234CAFE;
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h50;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_ce, mem_we, mem_addr} !== {3'b011, 32'h52}) begin
      errors++;
      $display("FAIL b2b hold: got %h expected %h", {req_ready, mem_ce, mem_we, mem_addr}, {3'b011, 32'h52});
    end
    @(posedge clk); #1;
    ref_mem[10'h52] = 8'hFE; ref_mem[10'h53] = 8'hCA;
    exp = ref_word(32'h50);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b early_rsp: got %b expected 0", rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, exp} || exp !== 32'hCAFE0304) begin
      errors++;
      $display("FAIL b2b lw: got %b/%h expected 1/%h", rsp_valid, rsp_data, 32'hCAFE0304);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b pulse: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'd3, 32'h10, 32'h0, "ld_f3_011");
    issue(1'b0, 3'd6, 32'h10, 32'h0, "ld_f3_110");
    issue(1'b0, 3'd7, 32'h10, 32'h0, "ld_f3_111");
    for (int f = 3; f < 8; f++) issue(1'b1, 3'(f), 32'h60, $urandom, "st_illegal");
    @(posedge clk); #1;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_pulse: got %b expected 0", fault);
    end
  endtask

  task automatic test_bound();
    issue(1'b0, 3'd2, 32'h3FC, 32'h0, "lw_0x3fc");
    issue(1'b0, 3'd2, 32'h3FE, 32'h0, "lw_0x3fe");
    issue(1'b1, 3'd0, 32'h3FF, 32'h0000005A, "sb_0x3ff");
  endtask

  task automatic test_reset_during_rmw();
    poke_word(32'h40, 32'hA1B2C3D4);
    poke_word(32'h44, 32'h99887766);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h41; req_wdata = 32'hEE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, mem_ce, mem_we} !== 3'b100) begin
      errors++;
      $display("FAIL rst_rmw bus: got %b expected 100", {req_ready, mem_ce, mem_we});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[10'(32'h41 + 32'(k))] !== ref_mem[10'(32'h41 + 32'(k))]) begin
        errors++;
        $display("FAIL rst_rmw byte %0d: got %h expected %h", k,
                 mem[10'(32'h41 + 32'(k))], ref_mem[10'(32'h41 + 32'(k))]);
      end
    end
    checks++;
    if (rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_rmw rsp_data: got %h expected 0", rsp_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, MEM_BYTES - 1)), $urandom, "random");
    for (int b = 0; b < MEM_BYTES; b++) begin
      checks++;
      if (mem[b] !== ref_mem[b]) begin
        errors++;
        $display("FAIL sweep byte %h: got %h expected %h", b, mem[b], ref_mem[b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sw();
    test_sub_store();
    test_back_to_back();
    test_illegal();
    test_bound();
    test_reset_during_rmw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
